// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer driving DDS frequency word K and phase offset P
module dds_sweep_ctrl #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [KW-1:0] cfg_k_start,
  input  logic [KW-1:0] cfg_k_stop,
  input  logic [KW-1:0] cfg_k_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  output logic [KW-1:0] K,
  output logic [PW-1:0] P,
  output logic          k_valid,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic dir;
  logic [1:0] s_mode;
  logic [KW-1:0] s_start, s_stop, s_step;
  logic [DW-1:0] s_dl, cnt, dl;
  logic cfg_bad, up_bnd, dn_bnd;
  // Boundary tests are one bit wider so K+step can never wrap past 2^KW.
  always_comb begin
    cfg_bad = cfg_k_step == '0 || cfg_k_start > cfg_k_stop || mode == 2'b11;
    dl = cfg_dwell == '0 ? '0 : cfg_dwell - DW'(1);
    up_bnd = ({1'b0, K} + {1'b0, s_step}) > {1'b0, s_stop};
    dn_bnd = (K - s_start) < s_step;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir <= 1'b0;
      s_mode <= '0;
      s_start <= '0;
      s_stop <= '0;
      s_step <= '0;
      s_dl <= '0;
      cnt <= '0;
      K <= '0;
      P <= '0;
      k_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      k_valid <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy <= 1'b0;
      end else if (state == IDLE) begin
        if (start && cfg_bad) cfg_err <= 1'b1;
        else if (start) begin
          s_mode <= mode;
          s_start <= cfg_k_start;
          s_stop <= cfg_k_stop;
          s_step <= cfg_k_step;
          s_dl <= dl;
          cnt <= dl;
          K <= cfg_k_start;
          P <= cfg_phase;
          k_valid <= 1'b1;
          busy <= 1'b1;
          dir <= 1'b0;
          state <= RUN;
        end
      end else if (cnt != '0) cnt <= cnt - DW'(1);
      else begin
        cnt <= s_dl;
        if (!dir && !up_bnd) begin
          K <= K + s_step;
          k_valid <= 1'b1;
        end else if (dir && !dn_bnd) begin
          K <= K - s_step;
          k_valid <= 1'b1;
        end else if (dir) begin
          dir <= 1'b0;
          if (!up_bnd) begin
            K <= K + s_step;
            k_valid <= 1'b1;
          end
        end else if (s_mode == 2'b01) begin
          K <= s_start;
          k_valid <= 1'b1;
        end else if (s_mode == 2'b10) begin
          dir <= 1'b1;
          if (!dn_bnd) begin
            K <= K - s_step;
            k_valid <= 1'b1;
          end
        end else begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] mode = '0;
  logic [31:0] cfg_k_start = '0, cfg_k_stop = '0, cfg_k_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic [10:0] cfg_phase = '0;
  logic [31:0] K;
  logic [10:0] P;
  logic k_valid, busy, done, cfg_err;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  dds_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .cfg_k_start(cfg_k_start), .cfg_k_stop(cfg_k_stop), .cfg_k_step(cfg_k_step),
    .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase),
    .K(K), .P(P), .k_valid(k_valid), .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [1:0] m, input logic [31:0] ks, input logic [31:0] ke,
                          input logic [31:0] st, input logic [15:0] dw, input logic [10:0] ph);
    mode = m;
    cfg_k_start = ks;
    cfg_k_stop = ke;
    cfg_k_step = st;
    cfg_dwell = dw;
    cfg_phase = ph;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({busy, k_valid, done, cfg_err, P, K} !== 47'h0) begin
      bad++;
      $display("FAIL reset got=%h exp=0", {busy, k_valid, done, cfg_err, P, K});
    end
  endtask
  task automatic test_single();
    int pulses = 0;
    do_start(2'b00, 100, 400, 100, 3, 11'h123);
    for (int i = 0; i < 12; i++) begin
      total++;
      pulses += int'(k_valid);
      if ({busy, k_valid, done, cfg_err, P, K} !== {1'b1, i % 3 == 0, 2'b00, 11'h123, 32'(100 * (i / 3 + 1))}) begin
        bad++;
        $display("FAIL single cyc%0d got=%h exp K=%0d", i, {busy, k_valid, done, cfg_err, P, K}, 100 * (i / 3 + 1));
      end
      tick();
    end
    total++;
    if (pulses !== 4) begin
      bad++;
      $display("FAIL single_pulses got=%0d exp=4", pulses);
    end
    total++;
    if ({busy, k_valid, done, cfg_err, K} !== {4'b0010, 32'd400}) begin
      bad++;
      $display("FAIL single_done got=%h exp=%h", {busy, k_valid, done, cfg_err, K}, {4'b0010, 32'd400});
    end
    tick();
    total++;
    if ({busy, k_valid, done, cfg_err, K} !== {4'b0000, 32'd400}) begin
      bad++;
      $display("FAIL single_hold got=%h exp=%h", {busy, k_valid, done, cfg_err, K}, {4'b0000, 32'd400});
    end
  endtask
  task automatic test_wrap();
    do_start(2'b01, 0, 250, 100, 1, 11'h0);
    for (int i = 0; i < 7; i++) begin
      total++;
      if ({busy, k_valid, done, K} !== {3'b110, 32'(100 * (i % 3))}) begin
        bad++;
        $display("FAIL wrap cyc%0d got=%h exp K=%0d", i, {busy, k_valid, done, K}, 100 * (i % 3));
      end
      tick();
    end
    do_abort();
    total++;
    if ({busy, k_valid, done, K} !== {3'b000, 32'd100}) begin
      bad++;
      $display("FAIL wrap_abort got=%h exp=%h", {busy, k_valid, done, K}, {3'b000, 32'd100});
    end
    tick();
    total++;
    if ({busy, done, K} !== {2'b00, 32'd100}) begin
      bad++;
      $display("FAIL wrap_abort_hold got=%h exp=%h", {busy, done, K}, {2'b00, 32'd100});
    end
  endtask
  task automatic test_triangle();
    logic [31:0] seq [9] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd30, 32'd20, 32'd10, 32'd20, 32'd30};
    do_start(2'b10, 10, 40, 10, 2, 11'h0);
    for (int i = 0; i < 18; i++) begin
      total++;
      if ({busy, k_valid, done, K} !== {1'b1, i % 2 == 0, 1'b0, seq[i / 2]}) begin
        bad++;
        $display("FAIL tri cyc%0d got=%h exp K=%0d", i, {busy, k_valid, done, K}, seq[i / 2]);
      end
      tick();
    end
    do_abort();
    do_start(2'b10, 10, 10, 10, 1, 11'h0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({busy, k_valid, done, K} !== {1'b1, i == 0, 1'b0, 32'd10}) begin
        bad++;
        $display("FAIL tri_point cyc%0d got=%h exp K=10", i, {busy, k_valid, done, K});
      end
      tick();
    end
    do_abort();
  endtask
  task automatic test_overflow();
    do_start(2'b00, 32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 1, 11'h0);
    total++;
    if ({busy, k_valid, done, K} !== {3'b110, 32'hFFFFFF00}) begin
      bad++;
      $display("FAIL ovf_k0 got=%h exp=%h", {busy, k_valid, done, K}, {3'b110, 32'hFFFFFF00});
    end
    tick();
    total++;
    if ({busy, k_valid, done, K} !== {3'b110, 32'hFFFFFF80}) begin
      bad++;
      $display("FAIL ovf_k1 got=%h exp=%h", {busy, k_valid, done, K}, {3'b110, 32'hFFFFFF80});
    end
    tick();
    total++;
    if ({busy, k_valid, done, K} !== {3'b001, 32'hFFFFFF80}) begin
      bad++;
      $display("FAIL ovf_done got=%h exp=%h", {busy, k_valid, done, K}, {3'b001, 32'hFFFFFF80});
    end
    tick();
  endtask
  task automatic test_cfg_err();
    logic [1:0] m [3] = '{2'b00, 2'b00, 2'b11};
    logic [31:0] ks [3] = '{32'd0, 32'd50, 32'd0};
    logic [31:0] st [3] = '{32'd0, 32'd10, 32'd10};
    for (int i = 0; i < 3; i++) begin
      do_start(m[i], ks[i], 40, st[i], 1, 11'h7);
      total++;
      if ({busy, k_valid, done, cfg_err, K} !== {4'b0001, 32'hFFFFFF80}) begin
        bad++;
        $display("FAIL cfg_err%0d got=%h exp=%h", i, {busy, k_valid, done, cfg_err, K}, {4'b0001, 32'hFFFFFF80});
      end
      tick();
      total++;
      if ({busy, cfg_err} !== 2'b00) begin
        bad++;
        $display("FAIL cfg_err_pulse%0d got=%b exp=00", i, {busy, cfg_err});
      end
    end
    do_start(2'b00, 0, 20, 10, 0, 11'h0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({busy, k_valid, done, K} !== {3'b110, 32'(10 * i)}) begin
        bad++;
        $display("FAIL dwell0 cyc%0d got=%h exp K=%0d", i, {busy, k_valid, done, K}, 10 * i);
      end
      tick();
    end
    total++;
    if ({busy, done, K} !== {2'b01, 32'd20}) begin
      bad++;
      $display("FAIL dwell0_done got=%h exp=%h", {busy, done, K}, {2'b01, 32'd20});
    end
    tick();
  endtask
  task automatic test_back_to_back();
    do_start(2'b00, 0, 30, 10, 2, 11'h0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({busy, k_valid, done, K} !== {1'b1, i % 2 == 0, 1'b0, 32'(10 * (i / 2))}) begin
        bad++;
        $display("FAIL ignore cyc%0d got=%h exp K=%0d", i, {busy, k_valid, done, K}, 10 * (i / 2));
      end
      if (i == 3) begin
        cfg_k_start = 500;
        cfg_k_stop = 900;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    total++;
    if ({busy, done, K} !== {2'b01, 32'd30}) begin
      bad++;
      $display("FAIL ignore_done got=%h exp=%h", {busy, done, K}, {2'b01, 32'd30});
    end
    tick();
    do_start(2'b01, 5, 50, 5, 1, 11'h5);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, k_valid, done, cfg_err, P, K} !== 47'h0) begin
      bad++;
      $display("FAIL rst_mid got=%h exp=0", {busy, k_valid, done, cfg_err, P, K});
    end
    abort = 1'b1;
    do_start(2'b00, 7, 70, 7, 1, 11'h9);
    abort = 1'b0;
    total++;
    if ({busy, k_valid, done, cfg_err, P, K} !== 47'h0) begin
      bad++;
      $display("FAIL abort_start got=%h exp=0", {busy, k_valid, done, cfg_err, P, K});
    end
    tick();
    total++;
    if ({busy, k_valid} !== 2'b00) begin
      bad++;
      $display("FAIL abort_start_idle got=%b exp=00", {busy, k_valid});
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_triangle();
    test_overflow();
    test_cfg_err();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
